// File: rtl/gpio_int_pkg.sv
// gpio_int_pkg: shared widths and FSM state type for the GPIO interrupt controller
package gpio_int_pkg;
  localparam int INT_CODE_W = 7;
  localparam int MAX_SRC = 128;
  typedef enum logic [1:0] {IDLE, REQ, ACK} state_t;
endpackage

// File: rtl/gpio_int_prio_enc.sv
// gpio_int_prio_enc: highest-set-index encoder (req -> idx, vld) built as a binary-halving search over a 128-bit padded vector
module gpio_int_prio_enc
  import gpio_int_pkg::*;
#(
  parameter int NUM_SRC = 8
) (
  input  logic [NUM_SRC-1:0]    req,
  output logic [INT_CODE_W-1:0] idx,
  output logic                  vld
);
  always_comb begin
    logic [MAX_SRC-1:0] w;
    logic hi;
    w = MAX_SRC'(req);
    hi = 1'b0;
    idx = '0;
    for (int k = INT_CODE_W - 1; k >= 0; k--) begin
      hi = |(w >> (1 << k));
      idx[k] = hi;
      w = hi ? w >> (1 << k) : w & ((MAX_SRC'(1) << (1 << k)) - MAX_SRC'(1));
    end
  end
  assign vld = |req;
endmodule

// File: rtl/gpio_int_ctrl.sv
// gpio_int_ctrl: GPIO interrupt collector, highest-index priority, INTR/INTA_N handshake with withdrawal and idle gap; edge triggers built only with GPIO_INT_EDGE_EN
module gpio_int_ctrl
  import gpio_int_pkg::*;
#(
  parameter int NUM_SRC   = 8,
  parameter int CODE_BASE = 0
) (
  input  logic                  clk_cpu,
  input  logic                  rst_cpu,
  input  logic [NUM_SRC-1:0]    int_src,
  input  logic [NUM_SRC-1:0]    int_mask,
  input  logic [NUM_SRC-1:0]    int_edge,
  input  logic [NUM_SRC-1:0]    int_clr,
  output logic [NUM_SRC-1:0]    int_pend,
  output logic                  INTR,
  output logic [INT_CODE_W-1:0] INT_CODE,
  input  logic                  INTA_N,
  output logic                  int_busy
);
  state_t state, nxt;
  logic [NUM_SRC-1:0] trig, act, win_oh, ack_clr;
  logic [INT_CODE_W-1:0] idx;
  logic vld, ack;
`ifdef GPIO_INT_EDGE_EN
  logic [NUM_SRC-1:0] src_d;
  always_ff @(posedge clk_cpu)
    src_d <= rst_cpu ? '0 : int_src;
  assign trig = int_src & ~(int_edge & src_d);
`else
  logic unused_edge;
  assign unused_edge = ^int_edge;
  assign trig = int_src;
`endif
  assign act = int_pend & int_mask;
  assign ack = (state == REQ) && !INTA_N;
  assign ack_clr = ack ? win_oh : '0;
  gpio_int_prio_enc #(.NUM_SRC(NUM_SRC)) u_enc (
    .req(act),
    .idx(idx),
    .vld(vld)
  );
  // acknowledge beats withdrawal when both happen in the same REQ cycle
  always_comb begin
    nxt = state;
    case (state)
      IDLE: nxt = vld ? REQ : IDLE;
      REQ:  nxt = ack ? ACK : (|(act & win_oh)) ? REQ : IDLE;
      ACK:  nxt = INTA_N ? IDLE : ACK;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk_cpu) begin
    if (rst_cpu) begin
      state    <= IDLE;
      int_pend <= '0;
      win_oh   <= '0;
      INTR     <= 1'b0;
      INT_CODE <= '0;
      int_busy <= 1'b0;
    end else begin
      state    <= nxt;
      int_pend <= (int_pend & ~(int_clr | ack_clr)) | trig;
      INTR     <= nxt == REQ;
      int_busy <= nxt != IDLE;
      if (state == IDLE && vld) begin
        win_oh   <= NUM_SRC'(1) << idx;
        INT_CODE <= INT_CODE_W'(CODE_BASE) + idx;
      end
    end
  end
endmodule
